// File: rtl/filter_out_downsamp.sv
// Receive-side symbol decimator: picks one matched-filter sample per symbol
// at a programmable phase and presents it with a one-cycle valid strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not aligned; no captures, phase counter held at 0
// RUN   | aligned by sync; capture on tick when phase index matches
module filter_out_downsamp #(
  parameter int WIDTH   = 32,
  parameter int OSR     = 8,
  parameter int PHASE_W = 4
) (
  input  logic               clk_filter_sample,
  input  logic               rst_n,
  input  logic [1:0]         baud_rate,
  input  logic               sync,
  input  logic [PHASE_W-1:0] samp_phase,
  input  logic [WIDTH-1:0]   samp_i,
  input  logic [WIDTH-1:0]   samp_q,
  output logic [WIDTH-1:0]   symb_i,
  output logic [WIDTH-1:0]   symb_q,
  output logic               symb_valid,
  output logic               samp_tick,
  output logic               locked
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PHASE_W-1:0] PH_MAX = PHASE_W'(OSR - 1);

  state_t             state_q, state_d;
  logic [2:0]         pcnt_q, pcnt_d;
  logic [PHASE_W-1:0] pidx_q, pidx_d;
  logic [1:0]         baud_q, baud_d;
  logic [WIDTH-1:0]   symb_i_q, symb_i_d;
  logic [WIDTH-1:0]   symb_q_q, symb_q_d;
  logic               symb_valid_q, symb_valid_d;

  logic [2:0]         mask;
  logic               tick;
  logic               change;
  logic [PHASE_W-1:0] ph;
  logic               capture;

  // Prescaler decode, baud-change detect, phase clamp and capture qualifier
  always_comb begin
    mask = 3'b000;
    case (baud_rate)
      2'b00:   mask = 3'b111;
      2'b01:   mask = 3'b011;
      2'b10:   mask = 3'b001;
      default: mask = 3'b000;
    endcase
    tick    = ((pcnt_q & mask) == mask);
    change  = (baud_rate != baud_q);
    ph      = (samp_phase > PH_MAX) ? PH_MAX : samp_phase;
    capture = (state_q == RUN) && tick && (pidx_q == ph) && !sync && !change;
  end

  // Next-state logic: a baud change wins over sync
  always_comb begin
    state_d = state_q;
    if (change) begin
      state_d = IDLE;
    end else if (sync) begin
      state_d = RUN;
    end
  end

  // State register
  always_ff @(posedge clk_filter_sample) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, baud history and capture next values
  always_comb begin
    pcnt_d       = pcnt_q + 3'd1;
    pidx_d       = pidx_q;
    baud_d       = baud_rate;
    symb_i_d     = symb_i_q;
    symb_q_d     = symb_q_q;
    symb_valid_d = 1'b0;
    if (change || sync) begin
      pcnt_d = '0;
      pidx_d = '0;
    end else if (state_q == IDLE) begin
      pidx_d = '0;
    end else if (tick) begin
      pidx_d = (pidx_q == PH_MAX) ? '0 : pidx_q + PHASE_W'(1);
    end
    if (capture) begin
      symb_i_d     = samp_i;
      symb_q_d     = samp_q;
      symb_valid_d = 1'b1;
    end
  end

  // Datapath registers; reset drops any strobe pending from this cycle
  always_ff @(posedge clk_filter_sample) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      pidx_q       <= '0;
      baud_q       <= baud_rate;
      symb_i_q     <= '0;
      symb_q_q     <= '0;
      symb_valid_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      pidx_q       <= pidx_d;
      baud_q       <= baud_d;
      symb_i_q     <= symb_i_d;
      symb_q_q     <= symb_q_d;
      symb_valid_q <= symb_valid_d;
    end
  end

  assign symb_i     = symb_i_q;
  assign symb_q     = symb_q_q;
  assign symb_valid = symb_valid_q;
  assign samp_tick  = tick;
  assign locked     = (state_q == RUN);

endmodule

// File: tb/tb_filter_out_downsamp.sv
// Bench for filter_out_downsamp: directed scenarios plus random traffic,
// all checked cycle by cycle against an arithmetic reference model.
module tb_filter_out_downsamp;
  localparam int WIDTH   = 32;
  localparam int OSR     = 8;
  localparam int PHASE_W = 4;

  logic               clk_filter_sample = 1'b0;
  logic               rst_n;
  logic [1:0]         baud_rate;
  logic               sync;
  logic [PHASE_W-1:0] samp_phase;
  logic [WIDTH-1:0]   samp_i, samp_q;
  logic [WIDTH-1:0]   symb_i, symb_q;
  logic               symb_valid, samp_tick, locked;

  always #5 clk_filter_sample = ~clk_filter_sample;

  filter_out_downsamp #(.WIDTH(WIDTH), .OSR(OSR), .PHASE_W(PHASE_W)) dut (
    .clk_filter_sample(clk_filter_sample),
    .rst_n(rst_n),
    .baud_rate(baud_rate),
    .sync(sync),
    .samp_phase(samp_phase),
    .samp_i(samp_i),
    .samp_q(samp_q),
    .symb_i(symb_i),
    .symb_q(symb_q),
    .symb_valid(symb_valid),
    .samp_tick(samp_tick),
    .locked(locked)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  // Reference model: cycles since last realign, run flag, last baud seen
  int             m_k;
  bit             m_run;
  logic [1:0]     m_bq;
  logic           e_valid;
  logic [WIDTH-1:0] e_si, e_sq;

  int             v_cyc[$];
  logic [WIDTH-1:0] v_val[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: update the model from the sampled inputs, then compare
  task automatic step();
    int p, ph, pl;
    @(posedge clk_filter_sample);
    if (!rst_n) begin
      m_k = 0; m_run = 0; m_bq = baud_rate;
      e_valid = 0; e_si = '0; e_sq = '0;
    end else begin
      p  = 8 >> baud_rate;
      ph = (int'(samp_phase) > OSR - 1) ? OSR - 1 : int'(samp_phase);
      e_valid = 0;
      if (baud_rate != m_bq) begin
        m_run = 0; m_k = 0;
      end else if (sync) begin
        m_run = 1; m_k = 0;
      end else begin
        if (m_run && (m_k % p == p - 1) && ((m_k / p) % OSR == ph)) begin
          e_valid = 1; e_si = samp_i; e_sq = samp_q;
        end
        m_k++;
      end
      m_bq = baud_rate;
    end
    #1;
    pl = 8 >> baud_rate;
    chk("symb_valid", 32'(symb_valid), 32'(e_valid));
    chk("symb_i", symb_i, e_si);
    chk("symb_q", symb_q, e_sq);
    chk("locked", 32'(locked), 32'(m_run));
    chk("samp_tick", 32'(samp_tick), 32'((m_k % pl) == pl - 1));
    if (symb_valid) begin
      v_cyc.push_back(cyc + 1);
      v_val.push_back(symb_i);
    end
    cyc++;
    samp_i = WIDTH'(cyc);
    samp_q = $urandom;
    sync   = 1'b0;
  endtask

  task automatic begin_scen();
    cyc = 0;
    v_cyc.delete();
    v_val.delete();
    samp_i = '0;
  endtask

  task automatic verify_list(input string tag, input int n,
                             input int c0, input int d0, input int c1, input int d1);
    chk({tag, "_count"}, 32'(v_cyc.size()), 32'(n));
    if (v_cyc.size() == n && n >= 1) begin
      chk({tag, "_cyc0"}, 32'(v_cyc[0]), 32'(c0));
      chk({tag, "_val0"}, v_val[0], 32'(d0));
    end
    if (v_cyc.size() == n && n >= 2) begin
      chk({tag, "_cyc1"}, 32'(v_cyc[1]), 32'(c1));
      chk({tag, "_val1"}, v_val[1], 32'(d1));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    rst_n = 1'b0; baud_rate = 2'b11; sync = 1'b0; samp_phase = '0;
    samp_i = '0; samp_q = '0; cyc = 0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      sync = 1'($urandom); samp_i = $urandom; samp_q = $urandom;
      step();
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_symb_i", symb_i, 32'd0);
    end
    rst_n = 1'b1;

    // baud 11, phase 0, sync at 10
    begin_scen();
    while (cyc < 30) begin
      if (cyc == 10) sync = 1'b1;
      step();
      if (cyc == 11) chk("s1_locked", 32'(locked), 32'd1);
    end
    verify_list("s1", 3, 12, 11, 20, 19);
    if (v_cyc.size() == 3) chk("s1_cyc2", 32'(v_cyc[2]), 32'd28);

    // baud 00, phase 3, sync at 0
    baud_rate = 2'b00;
    step();
    chk("s2_unlock", 32'(locked), 32'd0);
    samp_phase = 4'd3;
    begin_scen();
    while (cyc < 100) begin
      if (cyc == 0) sync = 1'b1;
      step();
    end
    verify_list("s2", 2, 33, 32, 97, 96);

    // phase 12 clamps to 7
    baud_rate = 2'b11;
    step();
    samp_phase = 4'd12;
    begin_scen();
    while (cyc < 20) begin
      if (cyc == 0) sync = 1'b1;
      step();
    end
    verify_list("s3", 2, 9, 8, 17, 16);

    // baud 11 -> 10 mid-RUN, later resync on the 2-cycle grid
    samp_phase = 4'd2;
    begin_scen();
    while (cyc < 70) begin
      if (cyc == 0) sync = 1'b1;
      if (cyc == 20) begin
        baud_rate = 2'b10;
        held = symb_i;
        v_cyc.delete(); v_val.delete();
      end
      if (cyc == 40) begin
        chk("s4_no_strobe", 32'(v_cyc.size()), 32'd0);
        chk("s4_held", symb_i, held);
        sync = 1'b1;
      end
      step();
      if (cyc == 21) chk("s4_unlock", 32'(locked), 32'd0);
    end
    verify_list("s4", 2, 47, 46, 63, 62);

    // sync together with a baud change, then lone sync, then realign
    samp_phase = 4'd1;
    begin_scen();
    while (cyc < 20) begin
      if (cyc == 0) begin baud_rate = 2'b11; sync = 1'b1; end
      if (cyc == 3 || cyc == 13) sync = 1'b1;
      step();
      if (cyc == 1) chk("s5_idle", 32'(locked), 32'd0);
    end
    verify_list("s5", 2, 6, 5, 16, 15);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      samp_i = $urandom;
      if ($urandom_range(0, 39) == 0) sync = 1'b1;
      if ($urandom_range(0, 199) == 0) baud_rate = 2'($urandom);
      if ($urandom_range(0, 99) == 0) samp_phase = PHASE_W'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
